// File: rtl/mema_skew_buf.sv
// mema_skew_buf
// Multi-bank operand memory for the A side of a systolic array. Matrices of
// DIM x KDIM signed elements are loaded one row at a time into a circular
// queue of NBUF banks. The oldest loaded bank is streamed into the array's
// left edge with the diagonal skew built in: lane r is delayed r cycles, so
// at stream time t lane r carries A[r][t-r] (or 0 outside the matrix).
// While one bank streams, the next can be loaded (ping-pong for NBUF=2).
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   wr_en      write wr_data into row wr_row of the current write bank
//   wr_row     row index of the write
//   wr_data    row contents, element k = A[row][k]
//   wr_commit  mark the write bank loaded and advance the write pointer
//   start      request streaming of the oldest loaded bank
//   Aout       skewed lane outputs (registered)
//   valid      Aout carries a stream cycle
//   busy       stream in progress
//   done       one-cycle pulse, stream finished and bank freed
//   full       all NBUF banks loaded
//   empty      no bank loaded
module mema_skew_buf #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int KDIM    = 8,
  parameter int NBUF    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(DIM)-1:0]    wr_row,
  input  logic signed [BITS_AB-1:0] wr_data [KDIM],
  input  logic                      wr_commit,
  input  logic                      start,
  output logic signed [BITS_AB-1:0] Aout [DIM],
  output logic                      valid,
  output logic                      busy,
  output logic                      done,
  output logic                      full,
  output logic                      empty
);

  localparam int BW = $clog2(NBUF);
  localparam int CW = $clog2(NBUF + 1);
  localparam int TW = $clog2(KDIM + DIM);
  localparam logic [CW-1:0] FULL_CNT = CW'(NBUF);
  localparam logic [TW-1:0] T_LAST   = TW'(KDIM + DIM - 2);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic signed [BITS_AB-1:0] r_mem [NBUF][DIM][KDIM];
  logic signed [BITS_AB-1:0] r_aout [DIM];
  logic signed [BITS_AB-1:0] w_laneNext [DIM];

  logic [BW-1:0] r_wbank;
  logic [BW-1:0] r_rbank;
  logic [BW-1:0] w_nextBank;
  logic [BW-1:0] w_readBank;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_t;
  logic [TW-1:0] w_tNext;
  logic          r_done;

  logic w_full, w_empty, w_avail, w_accept, w_last, w_commit, w_write, w_load;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // The bank finishing in a done cycle is only released at the end of that
  // cycle, so a start there must look past it: it needs a second loaded bank
  // and streams the one after the current read pointer.
  assign w_avail    = r_done ? (r_count > CW'(1)) : !w_empty;
  assign w_nextBank = r_rbank + BW'(r_done);

  assign w_accept = (r_state == IDLE) && start && w_avail;
  assign w_last   = (r_state == STREAM) && (r_t == T_LAST);
  assign w_commit = wr_commit && !w_full;
  assign w_write  = wr_en && !w_full;

  // w_load is high when the coming cycle is a stream cycle; Aout is loaded
  // one edge ahead so the t=0 values appear right after acceptance.
  assign w_load     = w_accept || ((r_state == STREAM) && !w_last);
  assign w_tNext    = w_accept ? '0 : r_t + TW'(1);
  assign w_readBank = w_accept ? w_nextBank : r_rbank;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // Next-state logic: a stream runs from acceptance to its last time step.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNext = STREAM;
      STREAM:  if (w_last)   w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Skew selection: lane r takes column k when t == r + k, otherwise 0.
  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      w_laneNext[r] = '0;
      for (int k = 0; k < KDIM; k++) begin
        if (int'(w_tNext) == r + k) w_laneNext[r] = r_mem[w_readBank][r][k];
      end
    end
  end

  // Bank storage has no reset; stale rows are allowed to survive.
  // Writes are blocked while full, which also protects the bank being streamed.
  always_ff @(posedge clk) begin
    if (w_write) begin
      for (int k = 0; k < KDIM; k++) r_mem[r_wbank][wr_row][k] <= wr_data[k];
    end
  end

  // Queue pointers, occupancy, stream counter and the registered outputs.
  // Freeing a bank happens at the end of the done cycle; a commit in that
  // same cycle cancels out the count change while both pointers move.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbank <= '0;
      r_rbank <= '0;
      r_count <= '0;
      r_t     <= '0;
      r_done  <= 1'b0;
      for (int r = 0; r < DIM; r++) r_aout[r] <= '0;
    end else begin
      r_done <= w_last;
      if (w_commit) r_wbank <= r_wbank + BW'(1);
      if (r_done)   r_rbank <= r_rbank + BW'(1);
      if (w_commit && !r_done)      r_count <= r_count + CW'(1);
      else if (!w_commit && r_done) r_count <= r_count - CW'(1);
      if (w_load) r_t <= w_tNext;
      for (int r = 0; r < DIM; r++) r_aout[r] <= w_load ? w_laneNext[r] : '0;
    end
  end

  assign Aout  = r_aout;
  assign valid = (r_state == STREAM);
  assign busy  = (r_state == STREAM);
  assign done  = r_done;
  assign full  = w_full;
  assign empty = w_empty;

endmodule
